// File: rtl/dictmem_scheduler.sv
// dictmem_scheduler: shares the single-port DictMem ROM between the processor load path (P)
// and the dictionary-scan engine (S), then tags each returned word back to its requester.
module dictmem_scheduler #(
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          p_req,
    input  logic [AW-1:0] p_addr,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic [DW-1:0] p_rdata,
    input  logic          s_req,
    input  logic [AW-1:0] s_addr,
    input  logic          s_lock,
    output logic          s_gnt,
    output logic          s_rvalid,
    output logic [DW-1:0] s_rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          starve_force
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_LIMIT - 1);
    localparam logic [BCW-1:0] BURST_TOP  = BCW'(BURST_MAX - 1);

    typedef enum logic {ARB, S_BURST} state_e;

    state_e            state_q, state_d;
    logic [SCW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [BCW-1:0]    burst_cnt_q, burst_cnt_d;
    logic              p_owed_q, p_owed_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d, id_q, id_d;
    logic [DW-1:0]     p_rdata_q, p_rdata_d, s_rdata_q, s_rdata_d;
    logic              p_win, s_win, force_win;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        p_owed_d    = p_owed_q;
        p_win       = 1'b0;
        s_win       = 1'b0;
        force_win   = 1'b0;
        unique case (state_q)
            ARB: begin
                if (p_req && p_owed_q) begin
                    p_win = 1'b1;
                end else if (s_req && starve_cnt_q == STARVE_TOP) begin
                    s_win     = 1'b1;
                    force_win = 1'b1;
                end else if (p_req) begin
                    p_win = 1'b1;
                end else if (s_req) begin
                    s_win = 1'b1;
                end
                if (s_win && s_lock) begin
                    burst_cnt_d = BCW'(1);
                    if (BURST_MAX > 1) state_d = S_BURST;
                    else               p_owed_d = p_req;
                end
            end
            S_BURST: begin
                s_win = s_req;
                if (s_req) burst_cnt_d = burst_cnt_q + 1'b1;
                // A full-length burst owes P the next slot so S cannot immediately re-lock.
                if (s_req && burst_cnt_q == BURST_TOP) begin
                    state_d  = ARB;
                    p_owed_d = p_req;
                end else if (!s_req || !s_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        if (p_win || !p_req) p_owed_d = 1'b0;
    end

    // Grants are forced low while reset is held so nothing reaches the ROM.
    assign p_gnt        = p_win & reset_n;
    assign s_gnt        = s_win & reset_n;
    assign starve_force = force_win & reset_n;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!s_req || s_gnt)                starve_cnt_d = '0;
        else if (starve_cnt_q != STARVE_TOP) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_comb begin
        addr_d = addr_q;
        if (p_gnt)      addr_d = p_addr;
        else if (s_gnt) addr_d = s_addr;
        vld_d[0] = p_gnt | s_gnt;
        id_d[0]  = s_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
        p_rdata_d = p_rvalid ? rom_q : p_rdata_q;
        s_rdata_d = s_rvalid ? rom_q : s_rdata_q;
    end

    assign p_rvalid = vld_q[RD_LAT-1] & ~id_q[RD_LAT-1];
    assign s_rvalid = vld_q[RD_LAT-1] &  id_q[RD_LAT-1];
    assign rom_addr = addr_d;
    assign p_rdata  = p_rdata_d;
    assign s_rdata  = s_rdata_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            p_owed_q     <= 1'b0;
            addr_q       <= '0;
            // NOTE: the latency pipe is reset so reads in flight at reset never produce an rvalid.
            vld_q        <= '0;
            id_q         <= '0;
            p_rdata_q    <= '0;
            s_rdata_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from pre-edge values.
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            p_owed_q     <= p_owed_d;
            addr_q       <= addr_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
            p_rdata_q    <= p_rdata_d;
            s_rdata_q    <= s_rdata_d;
        end
    end

endmodule

// File: tb/tb_dictmem_scheduler.sv
// Bench for dictmem_scheduler: a ROM model with RD_LAT pipeline, a per-requester
// scoreboard of expected words, and one task per scenario.
module tb_dictmem_scheduler;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          p_req, s_req, s_lock;
    logic [AW-1:0] p_addr, s_addr, rom_addr;
    logic          p_gnt, s_gnt, p_rvalid, s_rvalid, starve_force;
    logic [DW-1:0] p_rdata, s_rdata, rom_q;

    int checks   = 0;
    int failures = 0;
    int p_rv_cnt = 0;
    int s_rv_cnt = 0;

    logic [DW-1:0] pq[$];
    logic [DW-1:0] sq[$];

    logic          obs_p_gnt, obs_s_gnt, obs_force, obs_p_rvalid, obs_s_rvalid;
    logic [AW-1:0] obs_rom_addr;
    logic [AW-1:0] rom_pipe [RD_LAT];

    dictmem_scheduler #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(8), .BURST_MAX(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .p_req(p_req), .p_addr(p_addr), .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .s_req(s_req), .s_addr(s_addr), .s_lock(s_lock), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .rom_addr(rom_addr), .rom_q(rom_q), .starve_force(starve_force)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] dict(input logic [AW-1:0] a);
        return {4'hD, a, 4'h5, ~a};
    endfunction

    always @(posedge clock) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = dict(rom_pipe[RD_LAT-1]);

    task automatic set_idle();
        p_req = 1'b0; s_req = 1'b0; s_lock = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, score returns, queue accepted reads.
    task automatic tick();
        logic [DW-1:0] exp;
        @(negedge clock);
        obs_p_gnt = p_gnt; obs_s_gnt = s_gnt; obs_force = starve_force;
        obs_p_rvalid = p_rvalid; obs_s_rvalid = s_rvalid; obs_rom_addr = rom_addr;
        if (p_rvalid === 1'b1) begin
            p_rv_cnt++;
            checks++;
            if (pq.size() == 0) begin
                failures++;
                $display("FAIL p_return unexpected p_rvalid got=%h exp=none", p_rdata);
            end else begin
                exp = pq.pop_front();
                if (p_rdata !== exp) begin
                    failures++;
                    $display("FAIL p_return got=%h exp=%h", p_rdata, exp);
                end
            end
        end
        if (s_rvalid === 1'b1) begin
            s_rv_cnt++;
            checks++;
            if (sq.size() == 0) begin
                failures++;
                $display("FAIL s_return unexpected s_rvalid got=%h exp=none", s_rdata);
            end else begin
                exp = sq.pop_front();
                if (s_rdata !== exp) begin
                    failures++;
                    $display("FAIL s_return got=%h exp=%h", s_rdata, exp);
                end
            end
        end
        if (p_gnt === 1'b1) pq.push_back(dict(p_addr));
        if (s_gnt === 1'b1) sq.push_back(dict(s_addr));
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        set_idle();
        repeat (RD_LAT + 2) tick();
        checks++;
        if (pq.size() != 0 || sq.size() != 0) begin
            failures++;
            $display("FAIL drain outstanding p=%0d s=%0d exp=0", pq.size(), sq.size());
        end
    endtask

    task automatic test_reset();
        #2;
        p_req = 1'b1; s_req = 1'b1; s_lock = 1'b1; p_addr = 12'h7FF; s_addr = 12'h3C3;
        #1;
        checks++;
        if ({p_gnt, s_gnt, p_rvalid, s_rvalid, starve_force} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=00000", {p_gnt, s_gnt, p_rvalid, s_rvalid, starve_force});
        end
        checks++;
        if (rom_addr !== '0 || p_rdata !== '0 || s_rdata !== '0) begin
            failures++;
            $display("FAIL reset_data rom_addr=%h p_rdata=%h s_rdata=%h exp=0", rom_addr, p_rdata, s_rdata);
        end
        set_idle();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        int p0, s0, lat;
        p0 = p_rv_cnt; s0 = s_rv_cnt; lat = -1;
        p_req = 1'b1; p_addr = 12'h005;
        tick();
        checks++;
        if ({obs_p_gnt, obs_s_gnt} !== 2'b10 || obs_rom_addr !== 12'h005) begin
            failures++;
            $display("FAIL single_grant got=%b addr=%h exp=10 addr=005", {obs_p_gnt, obs_s_gnt}, obs_rom_addr);
        end
        p_req = 1'b0;
        for (int k = 1; k <= RD_LAT + 3; k++) begin
            tick();
            if (obs_p_rvalid === 1'b1 && lat < 0) lat = k;
        end
        checks++;
        if (lat != RD_LAT) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=%0d", lat, RD_LAT);
        end
        checks++;
        if (p_rv_cnt - p0 != 1 || s_rv_cnt - s0 != 0) begin
            failures++;
            $display("FAIL single_pulses got p=%0d s=%0d exp p=1 s=0", p_rv_cnt - p0, s_rv_cnt - s0);
        end
        checks++;
        if (p_rdata !== dict(12'h005)) begin
            failures++;
            $display("FAIL single_hold got=%h exp=%h", p_rdata, dict(12'h005));
        end
    endtask

    task automatic test_contention();
        int s0, np, ns;
        logic [2:0] exp;
        s0 = s_rv_cnt; np = 0; ns = 0;
        for (int c = 0; c < 16; c++) begin
            p_req = 1'b1; p_addr = 12'h020 + AW'(np);
            s_req = 1'b1; s_lock = 1'b0; s_addr = 12'h010 + AW'(ns);
            tick();
            exp = (c % 8 == 7) ? 3'b011 : 3'b100;
            checks++;
            if ({obs_p_gnt, obs_s_gnt, obs_force} !== exp) begin
                failures++;
                $display("FAIL contention cyc=%0d got=%b exp=%b", c, {obs_p_gnt, obs_s_gnt, obs_force}, exp);
            end
            if (c == 7) begin
                checks++;
                if (obs_rom_addr !== 12'h010) begin
                    failures++;
                    $display("FAIL contention_addr got=%h exp=010", obs_rom_addr);
                end
            end
            if (obs_p_gnt === 1'b1) np++;
            if (obs_s_gnt === 1'b1) ns++;
        end
        drain();
        checks++;
        if (s_rv_cnt - s0 != 2) begin
            failures++;
            $display("FAIL contention_s_pulses got=%0d exp=2", s_rv_cnt - s0);
        end
    endtask

    task automatic test_burst();
        int s0, p0, s_idx;
        logic [2:0] exp;
        s0 = s_rv_cnt; p0 = p_rv_cnt; s_idx = 0;
        for (int c = 0; c < 34; c++) begin
            s_req = (s_idx < 32); s_lock = 1'b1; s_addr = 12'h100 + AW'(s_idx);
            p_req = (c >= 1 && c <= 16) || (c >= 18 && c <= 33);
            p_addr = (c <= 16) ? 12'h200 : 12'h201;
            tick();
            exp = (c == 16 || c == 33) ? 3'b100 : 3'b010;
            checks++;
            if ({obs_p_gnt, obs_s_gnt, obs_force} !== exp) begin
                failures++;
                $display("FAIL burst cyc=%0d got=%b exp=%b", c, {obs_p_gnt, obs_s_gnt, obs_force}, exp);
            end
            if (obs_s_gnt === 1'b1) s_idx++;
        end
        drain();
        checks++;
        if (s_rv_cnt - s0 != 32 || p_rv_cnt - p0 != 2) begin
            failures++;
            $display("FAIL burst_pulses got s=%0d p=%0d exp s=32 p=2", s_rv_cnt - s0, p_rv_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rv;
        for (int c = 0; c <= RD_LAT + 3; c++) begin
            set_idle();
            if (c == 0) begin p_req = 1'b1; p_addr = 12'h001; end
            if (c == 1) begin s_req = 1'b1; s_addr = 12'h002; end
            if (c == 2) begin p_req = 1'b1; p_addr = 12'h003; end
            tick();
            if (c < 3) begin
                checks++;
                if ({obs_p_gnt, obs_s_gnt} !== ((c == 1) ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL b2b_grant cyc=%0d got=%b", c, {obs_p_gnt, obs_s_gnt});
                end
            end
            exp_rv = (c == RD_LAT || c == RD_LAT + 2) ? 2'b10 : (c == RD_LAT + 1) ? 2'b01 : 2'b00;
            checks++;
            if ({obs_p_rvalid, obs_s_rvalid} !== exp_rv) begin
                failures++;
                $display("FAIL b2b_rvalid cyc=%0d got=%b exp=%b", c, {obs_p_rvalid, obs_s_rvalid}, exp_rv);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        int p0, s0;
        set_idle();
        p_req = 1'b1; p_addr = 12'h030;
        tick();
        p_req = 1'b0; s_req = 1'b1; s_lock = 1'b1; s_addr = 12'h031;
        tick();
        p_req = 1'b1; s_addr = 12'h032;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({p_gnt, s_gnt, p_rvalid, s_rvalid, starve_force} !== 5'b0 || rom_addr !== '0 ||
            p_rdata !== '0 || s_rdata !== '0) begin
            failures++;
            $display("FAIL midreset_outputs ctl=%b addr=%h pd=%h sd=%h exp=0",
                     {p_gnt, s_gnt, p_rvalid, s_rvalid, starve_force}, rom_addr, p_rdata, s_rdata);
        end
        pq.delete();
        sq.delete();
        set_idle();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        p0 = p_rv_cnt; s0 = s_rv_cnt;
        repeat (RD_LAT + 3) tick();
        checks++;
        if (p_rv_cnt != p0 || s_rv_cnt != s0) begin
            failures++;
            $display("FAIL midreset_ghost got p=%0d s=%0d exp 0", p_rv_cnt - p0, s_rv_cnt - s0);
        end
        p_req = 1'b1; p_addr = 12'h040; s_req = 1'b1; s_lock = 1'b1; s_addr = 12'h041;
        tick();
        checks++;
        if ({obs_p_gnt, obs_s_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_arb got=%b exp=10", {obs_p_gnt, obs_s_gnt});
        end
        p_req = 1'b0;
        tick();
        drain();
        checks++;
        if (p_rv_cnt - p0 != 1 || s_rv_cnt - s0 != 1) begin
            failures++;
            $display("FAIL midreset_after got p=%0d s=%0d exp p=1 s=1", p_rv_cnt - p0, s_rv_cnt - s0);
        end
    endtask

    task automatic test_idle_hold();
        int p0, s0;
        p0 = p_rv_cnt; s0 = s_rv_cnt;
        p_req = 1'b1; p_addr = 12'h0AB;
        tick();
        set_idle();
        p_addr = 12'h555; s_addr = 12'h666;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs_rom_addr !== 12'h0AB || {obs_p_gnt, obs_s_gnt} !== 2'b00) begin
                failures++;
                $display("FAIL idle cyc=%0d addr=%h gnt=%b exp addr=0ab gnt=00", c, obs_rom_addr,
                         {obs_p_gnt, obs_s_gnt});
            end
        end
        checks++;
        if (p_rv_cnt - p0 != 1 || s_rv_cnt - s0 != 0 || p_rdata !== dict(12'h0AB)) begin
            failures++;
            $display("FAIL idle_return p=%0d s=%0d data=%h exp p=1 s=0 data=%h",
                     p_rv_cnt - p0, s_rv_cnt - s0, p_rdata, dict(12'h0AB));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        p_addr = '0; s_addr = '0;
        set_idle();
        test_reset();
        test_single_read();
        test_contention();
        test_burst();
        test_back_to_back();
        test_reset_mid_burst();
        test_idle_hold();
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
